// File: rtl/csr_access_seq.sv
// csr_access_seq: sequences CSR read-modify-write instructions and trap entry updates
// (mepc, mcause, mtval, mstatus) onto a single-port CSR file.
module csr_access_seq #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            req_v_i,
    output logic            req_rdy_o,
    input  logic [1:0]      req_op_i,
    input  logic [11:0]     req_adr_i,
    input  logic [XLEN-1:0] req_src_i,
    input  logic            req_src_zero_i,
    output logic            rsp_v_o,
    input  logic            rsp_rdy_i,
    output logic [XLEN-1:0] rsp_data_o,
    output logic            rsp_err_o,
    input  logic            trap_v_i,
    input  logic [XLEN-1:0] trap_pc_i,
    input  logic [XLEN-1:0] trap_cause_i,
    input  logic [XLEN-1:0] trap_tval_i,
    output logic            trap_done_o,
    output logic [XLEN-1:0] trap_target_o,
    output logic            csr_write_v_o,
    output logic [11:0]     csr_adr_read_o,
    output logic [11:0]     csr_adr_write_o,
    output logic [XLEN-1:0] csr_wdata_o,
    input  logic [XLEN-1:0] csr_rdata_i,
    input  logic [XLEN-1:0] csr_mtvec_i
);
    typedef enum logic [3:0] {IDLE, RD, WR, RSP, T_EPC, T_CAUSE, T_TVAL, T_STAT, T_DONE} state_t;
    state_t          r_state, w_next;
    logic [1:0]      r_op;
    logic [11:0]     r_adr;
    logic [XLEN-1:0] r_src, r_old, r_pc, r_cause, r_tval, r_ppc, r_pcause, r_ptval;
    logic            r_src_zero, r_pend;
    logic            w_accept, w_wr_req, w_ro, w_unused;
    logic [XLEN-1:0] w_new;
    assign w_accept  = req_v_i & req_rdy_o;
    assign w_wr_req  = !((r_op == 2'b01 || r_op == 2'b10) && r_src_zero);
    assign w_ro      = r_adr[11:10] == 2'b11;
    assign w_new     = r_op == 2'b01 ? (r_old | r_src) : r_op == 2'b10 ? (r_old & ~r_src) : r_src;
    assign req_rdy_o = reset_n && r_state == IDLE && !r_pend && !trap_v_i;
    assign w_unused  = ^{csr_mtvec_i[1:0], r_pc[1:0]};
    // Active trap fields are separate from the pending copy so a trap arriving
    // mid-sequence cannot corrupt the mcause/mtval still being written.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= IDLE;
            r_op       <= '0;
            r_adr      <= '0;
            r_src      <= '0;
            r_src_zero <= 1'b0;
            r_old      <= '0;
            r_pend     <= 1'b0;
            r_pc       <= '0;
            r_cause    <= '0;
            r_tval     <= '0;
            r_ppc      <= '0;
            r_pcause   <= '0;
            r_ptval    <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_op       <= req_op_i;
                r_adr      <= req_adr_i;
                r_src      <= req_src_i;
                r_src_zero <= req_src_zero_i;
            end
            if (r_state == RD) r_old <= csr_rdata_i;
            if (r_state == IDLE && r_pend) begin
                r_pend  <= 1'b0;
                r_pc    <= r_ppc;
                r_cause <= r_pcause;
                r_tval  <= r_ptval;
            end else if (r_state == IDLE && trap_v_i) begin
                r_pc    <= trap_pc_i;
                r_cause <= trap_cause_i;
                r_tval  <= trap_tval_i;
            end else if (r_state != IDLE && trap_v_i && !r_pend) begin
                r_pend   <= 1'b1;
                r_ppc    <= trap_pc_i;
                r_pcause <= trap_cause_i;
                r_ptval  <= trap_tval_i;
            end
        end
    end
    always_comb begin
        w_next          = r_state;
        rsp_v_o         = 1'b0;
        rsp_data_o      = '0;
        rsp_err_o       = 1'b0;
        trap_done_o     = 1'b0;
        trap_target_o   = '0;
        csr_write_v_o   = 1'b0;
        csr_adr_read_o  = '0;
        csr_adr_write_o = '0;
        csr_wdata_o     = '0;
        unique case (r_state)
            IDLE: w_next = (r_pend || trap_v_i) ? T_EPC : req_v_i ? RD : IDLE;
            RD: begin
                csr_adr_read_o = r_adr;
                w_next         = WR;
            end
            WR: begin
                csr_write_v_o   = w_wr_req && !w_ro;
                csr_adr_write_o = r_adr;
                csr_wdata_o     = w_new;
                w_next          = RSP;
            end
            RSP: begin
                rsp_v_o    = 1'b1;
                rsp_data_o = r_old;
                rsp_err_o  = w_wr_req && w_ro;
                w_next     = rsp_rdy_i ? IDLE : RSP;
            end
            T_EPC: begin
                csr_write_v_o   = 1'b1;
                csr_adr_write_o = 12'h341;
                csr_wdata_o     = {r_pc[XLEN-1:2], 2'b00};
                w_next          = T_CAUSE;
            end
            T_CAUSE: begin
                csr_write_v_o   = 1'b1;
                csr_adr_write_o = 12'h342;
                csr_wdata_o     = r_cause;
                w_next          = T_TVAL;
            end
            T_TVAL: begin
                csr_write_v_o   = 1'b1;
                csr_adr_write_o = 12'h343;
                csr_wdata_o     = r_tval;
                w_next          = T_STAT;
            end
            T_STAT: begin
                csr_adr_read_o     = 12'h300;
                csr_write_v_o      = 1'b1;
                csr_adr_write_o    = 12'h300;
                csr_wdata_o        = csr_rdata_i;
                csr_wdata_o[7]     = csr_rdata_i[3];
                csr_wdata_o[3]     = 1'b0;
                csr_wdata_o[12:11] = 2'b11;
                w_next             = T_DONE;
            end
            T_DONE: begin
                trap_done_o   = 1'b1;
                trap_target_o = {csr_mtvec_i[XLEN-1:2], 2'b00};
                w_next        = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end
endmodule

// File: doc/csr_access_seq.md
CSR_ACCESS_SEQ -- requirements
Module: csr_access_seq

Interface
REQ-001 Parameter XLEN, default 32, datapath width of all CSR data ports.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 req_v_i  input  1  CSR instruction request valid.
REQ-005 req_rdy_o  output  1  request accepted when req_v_i & req_rdy_o.
REQ-006 req_op_i  input  2  00 = RW, 01 = RS, 10 = RC; 11 treated as RW.
REQ-007 req_adr_i  input  12  target CSR address.
REQ-008 req_src_i  input  XLEN  source operand (rs1 value or zero-extended zimm).
REQ-009 req_src_zero_i  input  1  source field is x0/zimm=0.
REQ-010 rsp_v_o  output  1  response valid.
REQ-011 rsp_rdy_i  input  1  response consumed when rsp_v_o & rsp_rdy_i.
REQ-012 rsp_data_o  output  XLEN  old CSR value.
REQ-013 rsp_err_o  output  1  write attempted to a read-only CSR.
REQ-014 trap_v_i  input  1  single-cycle trap entry pulse.
REQ-015 trap_pc_i, trap_cause_i, trap_tval_i  input  XLEN each  trap PC, cause, value.
REQ-016 trap_done_o  output  1  one-cycle pulse, trap sequence complete.
REQ-017 trap_target_o  output  XLEN  handler address, valid with trap_done_o.
REQ-018 csr_write_v_o  output  1  CSR file write enable.
REQ-019 csr_adr_read_o, csr_adr_write_o  output  12 each  CSR file read/write addresses.
REQ-020 csr_wdata_o  output  XLEN  CSR file write data.
REQ-021 csr_rdata_i  input  XLEN  CSR file read data, combinational from csr_adr_read_o.
REQ-022 csr_mtvec_i  input  XLEN  current MTVEC value.

Function
REQ-023 FSM states: IDLE, RD, WR, RSP, T_EPC, T_CAUSE, T_TVAL, T_STAT, T_DONE.
REQ-024 req_rdy_o = 1 only in IDLE with no trap pending and trap_v_i = 0.
REQ-025 IDLE: trap_v_i or pending trap has priority -> T_EPC; else accepted request captures op/adr/src/src_zero -> RD.
REQ-026 RD: csr_adr_read_o = captured adr; csr_rdata_i registered into old_q; -> WR.
REQ-027 WR: new = src (RW), old_q | src (RS), old_q & ~src (RC); csr_adr_write_o = adr; -> RSP.
REQ-028 WR asserts csr_write_v_o unless (op RS/RC and src_zero) or adr[11:10] = 2'b11.
REQ-029 rsp_err_o = 1 in RSP iff adr[11:10] = 2'b11 and a write was required by REQ-028's first term; CSR left unmodified.
REQ-030 RSP: rsp_v_o = 1, rsp_data_o = old_q; held stable until rsp_rdy_i, then -> IDLE.
REQ-031 T_EPC writes 0x341 with {trap_pc[XLEN-1:2], 2'b00}; T_CAUSE writes 0x342 with cause; T_TVAL writes 0x343 with tval; one write per cycle.
REQ-032 T_STAT: csr_adr_read_o = 0x300, writes 0x300 same cycle with bit7 = rdata bit3, bit3 = 0, bits[12:11] = 2'b11, other bits unchanged.
REQ-033 T_DONE: trap_done_o = 1, trap_target_o = {csr_mtvec_i[XLEN-1:2], 2'b00}; -> IDLE.
REQ-034 trap_v_i outside IDLE sets pending flag and captures pc/cause/tval; further trap_v_i while pending is ignored.
REQ-035 Pending trap cleared on entry to T_EPC; trap_v_i in T_DONE is recorded as pending.
REQ-036 All outputs not driven by the current state are 0; csr_write_v_o never asserted in IDLE, RD, RSP, T_DONE.
REQ-037 Request latency: write strobe 2 cycles after acceptance, rsp_v_o 3 cycles after; trap_done_o 5 cycles after trap_v_i in IDLE.

Reset
REQ-038 reset_n low asynchronously forces IDLE, clears pending flag, old_q and all captured fields to 0.
REQ-039 During reset all outputs are 0 except req_rdy_o, which is 1 from the first cycle after release.
REQ-040 Reset mid-sequence aborts it; no further CSR writes or responses are issued for the aborted operation.

Verification
REQ-041 CSRRW adr 0x340, src 0xDEADBEEF, mscratch = 0x12345678 -> write 0x340 = 0xDEADBEEF at cycle +2, rsp_data_o = 0x12345678.
REQ-042 CSRRS adr 0x300, src 0x8, src_zero = 0, mstatus = 0x1800 -> write 0x1808; repeat with src_zero = 1 -> no write, rsp 0x1800.
REQ-043 CSRRC adr 0x304, src 0xF0, mie = 0xFF -> write 0x0F; CSRRW to 0xF14 -> no write, rsp_err_o = 1.
REQ-044 trap_v_i pc 0x80000106, cause 2, tval 0x13, mstatus 0x8, mtvec 0x80000101 -> writes 0x341 = 0x80000104, 0x342 = 2, 0x343 = 0x13, 0x300 = 0x1880; trap_target_o = 0x80000100.
REQ-045 trap_v_i during RSP with rsp_rdy_i held 0 for 4 cycles -> response held, then trap sequence runs before new requests; req_rdy_o = 0 throughout.
REQ-046 reset_n low in T_CAUSE -> no 0x343/0x300 writes, trap_done_o never pulses, IDLE with req_rdy_o = 1 after release.
